// File: rtl/pes_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pes_piso_tx
//  Purpose  : Parallel-in / serial-out frame transmitter. A word accepted
//             through a valid/ready handshake is sent on a registered,
//             idle-high serial line as:
//                 START(0), DATA_W payload bits MSB first,
//                 [PARITY (even)], STOP(1)
//             Back-to-back frames are supported: a word accepted during
//             STOP starts its START bit in the very next cycle.
//  Ports    : clk        - single clock, rising-edge active
//             reset      - synchronous reset, active low
//             load_data  - parallel word to serialise (DATA_W bits)
//             load_valid - producer offers load_data this cycle
//             load_ready - block can accept a word this cycle (IDLE/STOP)
//             serial_out - registered serial line, idle high
//             busy       - high from START through STOP
//             tx_done    - one-cycle pulse coincident with the stop bit
//  Config   : define PES_PISO_PARITY_EN to insert a one-cycle even-parity
//             bit between the last data bit and the stop bit.
//  Revision : 1.0 - initial release
// ============================================================================
module pes_piso_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int                c_cnt_w    = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

`ifdef PES_PISO_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [c_cnt_w-1:0]  r_cnt;
`ifdef PES_PISO_PARITY_EN
    logic                r_parity;
`endif

    // load_ready is registered and is only ever high in IDLE or STOP,
    // so it doubles as the "this state may accept" qualifier.
    logic w_accept;
    assign w_accept = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            serial_out <= 1'b1;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
`ifdef PES_PISO_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                IDLE, STOP: begin
                    if (w_accept) begin
                        r_state    <= START;
                        r_shreg    <= load_data;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef PES_PISO_PARITY_EN
                        r_parity   <= ^load_data;
`endif
                    end else begin
                        r_state    <= IDLE;
                        serial_out <= 1'b1;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end

                // The MSB goes out on the edge leaving START, so the
                // counter value seen during each DATA cycle is the number
                // of bits still to follow it.
                START: begin
                    r_state    <= DATA;
                    serial_out <= r_shreg[DATA_W-1];
                    r_shreg    <= {r_shreg[DATA_W-2:0], 1'b0};
                    r_cnt      <= c_cnt_load;
                end

                DATA: begin
                    if (r_cnt == '0) begin
`ifdef PES_PISO_PARITY_EN
                        r_state    <= PARITY;
                        serial_out <= r_parity;
`else
                        r_state    <= STOP;
                        serial_out <= 1'b1;
                        tx_done    <= 1'b1;
                        load_ready <= 1'b1;
`endif
                    end else begin
                        serial_out <= r_shreg[DATA_W-1];
                        r_shreg    <= {r_shreg[DATA_W-2:0], 1'b0};
                        r_cnt      <= r_cnt - c_cnt_one;
                    end
                end

`ifdef PES_PISO_PARITY_EN
                PARITY: begin
                    r_state    <= STOP;
                    serial_out <= 1'b1;
                    tx_done    <= 1'b1;
                    load_ready <= 1'b1;
                end
`endif

                default: begin
                    r_state    <= IDLE;
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pes_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pes_piso_tx
//  Purpose  : Self-checking bench for pes_piso_tx. Each cycle the expected
//             line state comes from a frame-level model: an accepted word
//             expands into a queue of per-cycle symbols (start, payload MSB
//             first, optional even parity, stop) that is replayed one per
//             clock; an empty queue means the idle line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pes_piso_tx;

    localparam int DATA_W = 8;
`ifdef PES_PISO_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 3;
`else
    localparam int FRAME_LEN = DATA_W + 2;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic              serial_out;
    logic              busy;
    logic              tx_done;

    pes_piso_tx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ser;
        logic bsy;
        logic done;
        logic rdy;
    } sym_t;

    sym_t q[$];
    sym_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic sym_t mk(logic s, logic b, logic d, logic r);
        sym_t t;
        t.ser = s; t.bsy = b; t.done = d; t.rdy = r;
        return t;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(logic [DATA_W-1:0] d);
        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = DATA_W - 1; i >= 0; i--)
            q.push_back(mk(d[i], 1'b1, 1'b0, 1'b0));
`ifdef PES_PISO_PARITY_EN
        q.push_back(mk(logic'($countones(d) % 2), 1'b1, 1'b0, 1'b0));
`endif
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1));
    endtask

    // One clock: update the model from the inputs present at the edge,
    // then compare all outputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            q.delete();
            cur = mk(1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
            if (load_valid && cur.rdy) push_frame(load_data);
            if (q.size() > 0) cur = q.pop_front();
            else              cur = mk(1'b1, 1'b0, 1'b0, 1'b1);
        end
        #1;
        check("serial_out", serial_out, cur.ser);
        check("busy",       busy,       cur.bsy);
        check("tx_done",    tx_done,    cur.done);
        check("load_ready", load_ready, cur.rdy);
    endtask

    initial begin
        logic [0:FRAME_LEN-1] a5_seq;
        int                   done_cnt;
`ifdef PES_PISO_PARITY_EN
        a5_seq = 11'b01010010101;
`else
        a5_seq = 10'b0101001011;
`endif
        cur = mk(1'b1, 1'b0, 1'b0, 1'b1);

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single 0xA5 frame, line also checked against a literal sequence
        load_data = 8'hA5; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("a5_bit0", serial_out, a5_seq[0]);
        for (int i = 1; i < FRAME_LEN; i++) begin
            tick();
            check("a5_seq", serial_out, a5_seq[i]);
        end
        tick();
        check("a5_idle", serial_out, 1'b1);
        repeat (2) tick();

        // 0x01 frame (odd ones count -> parity bit 1 when enabled)
        load_data = 8'h01; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (FRAME_LEN + 1) tick();

        // Back-to-back: valid held, 0x3C presented during the 0xA5 frame
        load_data = 8'hA5; load_valid = 1'b1;
        tick();
        load_data = 8'h3C;
        repeat (FRAME_LEN) tick();
        check("b2b_start", serial_out, 1'b0);
        load_valid = 1'b0;
        repeat (FRAME_LEN + 2) tick();

        // Reset after the third data bit of 0xFF: no tx_done afterwards
        load_data = 8'hFF; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            tick();
            if (tx_done) done_cnt++;
        end
        check("abort_no_done", logic'(done_cnt != 0), 1'b0);

        // Data changed during DATA of 0xC3; 0x00 only accepted at STOP
        load_data = 8'hC3; load_valid = 1'b1;
        tick();
        load_data = 8'h00;
        repeat (FRAME_LEN) tick();
        load_valid = 1'b0;
        repeat (FRAME_LEN + 2) tick();

        // load_valid held through reset: first start one cycle after release
        reset = 1'b0; load_data = 8'h5A; load_valid = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("post_reset_start", serial_out, 1'b0);
        load_valid = 1'b0;
        repeat (FRAME_LEN + 2) tick();

        // Randomised traffic with occasional resets
        repeat (500) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = DATA_W'($urandom);
            reset      = ($urandom_range(0, 59) != 0);
            tick();
        end
        reset = 1'b1; load_valid = 1'b0;
        repeat (FRAME_LEN + 3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
